// File: rtl/dma_burst_sched_if.sv
// Burst request channel between the burst scheduler and the DMA-to-AXI address/response side.
interface dma_burst_sched_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_BYTES = 64
);
  logic                  req_valid_o;
  logic [ADDR_W-1:0]     req_addr_o;
  logic [7:0]            req_alen_o;
  logic [2:0]            req_size_o;
  logic [DATA_BYTES-1:0] req_strb_o;
  logic                  req_ready_i;
  logic                  req_finish_i;

  modport master (
    output req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o,
    input  req_ready_i, req_finish_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o,
    output req_ready_i, req_finish_i
  );
endinterface

// File: rtl/dma_burst_sched.sv
// Splits one linear DMA segment into AXI INCR bursts, honouring max burst length,
// 4KB page boundaries and a cap on accepted-but-unfinished bursts.
module dma_burst_sched #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned DATA_BYTES = 64,
  parameter int unsigned MAX_BEATS  = 256,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  bytes_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [3:0]        outst_o,
  dma_burst_sched_if.master req
);

  localparam int unsigned SIZE_LOG = $clog2(DATA_BYTES);
  localparam int unsigned BEAT_W   = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        outst_q, outst_d;
  logic [7:0]        alen_q, alen_d;
  logic [BEAT_W-1:0] beats, beats_nx;
  logic              hs, fin_ok;

  // Beats of the next burst: smallest of remaining beats, MAX_BEATS and room left in the 4KB page.
  function automatic logic [BEAT_W-1:0] calc_beats(input logic [ADDR_W-1:0] a,
                                                   input logic [LEN_W-1:0]  r);
    logic [BEAT_W-1:0] b;
    logic [BEAT_W-1:0] pg;
    pg = (BEAT_W'(4096) - {1'b0, a[11:0]}) >> SIZE_LOG;
    b  = BEAT_W'(MAX_BEATS);
    if (pg < b) b = pg;
    if (r < LEN_W'(b)) b = BEAT_W'(r);
    return b;
  endfunction

  assign hs     = valid_q & req.req_ready_i;
  assign fin_ok = req.req_finish_i & (outst_q != 4'd0);
  assign beats  = calc_beats(cur_addr_q, rem_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_CHECK;
      S_CHECK: state_d = (mis_q || rem_q == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (hs) begin
          if (rem_q == LEN_W'(beats) || abort_q || abort_i) state_d = S_DRAIN;
        end else if (!valid_q && (abort_i || abort_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (outst_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    mis_d      = mis_q;
    err_d      = err_q;
    abort_d    = abort_q;
    outst_d    = outst_q + 4'(hs) - 4'(fin_ok);
    valid_d    = 1'b0;

    if (state_q == S_IDLE && start_i) begin
      cur_addr_d = addr_i;
      rem_d      = LEN_W'(bytes_i >> SIZE_LOG);
      mis_d      = (addr_i[SIZE_LOG-1:0] != '0) || (bytes_i[SIZE_LOG-1:0] != '0);
      err_d      = 1'b0;
    end
    if (state_q == S_CHECK && mis_q) err_d = 1'b1;
    if (hs) begin
      cur_addr_d = cur_addr_q + (ADDR_W'(beats) << SIZE_LOG);
      rem_d      = rem_q - LEN_W'(beats);
    end
    // An abort that arrives with a request pending is remembered until that handshake.
    if (state_q == S_ISSUE && abort_i && valid_q && !hs) abort_d = 1'b1;
    if (state_d != S_ISSUE) abort_d = 1'b0;

    beats_nx = calc_beats(cur_addr_d, rem_d);
    alen_d   = (beats_nx == '0) ? 8'd0 : 8'(beats_nx - BEAT_W'(1));

    // Held until accepted; a fresh request needs one idle cycle after a handshake.
    if (state_d == S_ISSUE) begin
      if (valid_q && !hs)                                valid_d = 1'b1;
      else if (!valid_q && outst_d < 4'(MAX_OUTST))      valid_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q <= '0;
      rem_q      <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      outst_q    <= 4'd0;
      alen_q     <= 8'd0;
    end else begin
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      outst_q    <= outst_d;
      alen_q     <= alen_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign outst_o         = outst_q;
  assign req.req_valid_o = valid_q;
  assign req.req_addr_o  = cur_addr_q;
  assign req.req_alen_o  = alen_q;
  assign req.req_size_o  = 3'(SIZE_LOG);
  assign req.req_strb_o  = '1;

endmodule
